dma_cfg_slave: RTL and testbench

- AXI4 write-slave register bank for the DMA engine on slave port S3; the CPU programs the DMA through it.
- Accepts AW/W bursts and produces source, destination, length and enable values for the DMA datapath core.
- Turns the 0->1 edge of enable into a one-cycle start pulse.
- Clears enable when the DMA core reports completion.

---
 rtl/dma_cfg_slave_if.sv | 67 ++++++
 rtl/dma_cfg_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_dma_cfg_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_cfg_slave_if.sv
// AXI4 channel bundle between the CPU interconnect (slave port S3) and the DMA config slave.
// The AR/R channels exist only when DMA_CFG_READBACK_EN is defined.
interface dma_cfg_slave_if;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic        AWVALID_S;
    logic        AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S;
    logic        WVALID_S;
    logic        WREADY_S;
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S;
`ifdef DMA_CFG_READBACK_EN
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
`endif

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
`ifdef DMA_CFG_READBACK_EN
        ,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
`endif
    );

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
`ifdef DMA_CFG_READBACK_EN
        ,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
`endif
    );
endinterface

// File: rtl/dma_cfg_slave.sv
// AXI4 write-slave register bank (DMAEN/DMASRC/DMADST/DMALEN) feeding the DMA datapath core.
// Define DMA_CFG_READBACK_EN to add the independent AR/R read path.
//
//   state  | meaning
//   W_ADDR | waiting for an AW handshake
//   W_DATA | accepting W beats into the indexed registers
//   W_RESP | holding BVALID until BREADY
//   R_ADDR | (readback) waiting for an AR handshake
//   R_DATA | (readback) returning beats until the RLAST beat is taken
module dma_cfg_slave #(
    parameter int ADDR_LSB = 2,
    parameter int LEN_BITS = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    dma_cfg_slave_if.slave      axi,
    output logic [31:0]         dma_src,
    output logic [31:0]         dma_dst,
    output logic [LEN_BITS-1:0] dma_len,
    output logic                dma_en,
    output logic                dma_start,
    input  logic                dma_done
);
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_e;

    wstate_e             wstate_q, wstate_d;
    logic [7:0]          wid_q, wid_d;
    logic [1:0]          widx_q, widx_d;
    logic                werr_win_q, werr_win_d;
    logic                wslverr_q, wslverr_d;
    logic [4:0]          wbeats_q, wbeats_d;
    logic                awready_q, wready_q, bvalid_q;
    logic [31:0]         src_q, src_d, dst_q, dst_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [31:0]         len_merged;
    logic                en_q, en_d, en_dly_q, start_q;
    logic                aw_fire, w_fire, b_fire, aw_out_of_win;

    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    assign aw_fire       = awready_q & axi.AWVALID_S;
    assign w_fire        = wready_q & axi.WVALID_S;
    assign b_fire        = bvalid_q & axi.BREADY_S;
    assign aw_out_of_win = |axi.AWADDR_S[15:ADDR_LSB+2];

    always_comb begin
        wstate_d   = wstate_q;
        wid_d      = wid_q;
        widx_d     = widx_q;
        werr_win_d = werr_win_q;
        wslverr_d  = wslverr_q;
        wbeats_d   = wbeats_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        len_merged = merge_strb(32'(len_q), axi.WDATA_S, axi.WSTRB_S);
        en_d       = en_q;
        // A DMAEN write below overrides a coincident completion.
        if (dma_done) en_d = 1'b0;
        case (wstate_q)
            W_ADDR: begin
                if (aw_fire) begin
                    wid_d      = axi.AWID_S;
                    widx_d     = axi.AWADDR_S[ADDR_LSB+1:ADDR_LSB];
                    werr_win_d = aw_out_of_win;
                    wslverr_d  = aw_out_of_win;
                    wbeats_d   = {1'b0, axi.AWLEN_S} + 5'd1;
                    wstate_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (!werr_win_q) begin
                        case (widx_q)
                            2'd0: if (axi.WSTRB_S[0]) en_d = axi.WDATA_S[0];
                            2'd1: if (!en_q) src_d = merge_strb(src_q, axi.WDATA_S, axi.WSTRB_S);
                            2'd2: if (!en_q) dst_d = merge_strb(dst_q, axi.WDATA_S, axi.WSTRB_S);
                            default: if (!en_q) len_d = len_merged[LEN_BITS-1:0];
                        endcase
                    end
                    widx_d = widx_q + 2'd1;
                    // WLAST must coincide with the final counted beat; it ends the burst regardless.
                    if (axi.WLAST_S != (wbeats_q == 5'd1)) wslverr_d = 1'b1;
                    if (wbeats_q != 5'd0) wbeats_d = wbeats_q - 5'd1;
                    if (axi.WLAST_S) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_fire) wstate_d = W_ADDR;
            end
            default: wstate_d = W_ADDR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q   <= W_ADDR;
            wid_q      <= '0;
            widx_q     <= '0;
            werr_win_q <= 1'b0;
            wslverr_q  <= 1'b0;
            wbeats_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            en_q       <= 1'b0;
            en_dly_q   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wid_q      <= wid_d;
            widx_q     <= widx_d;
            werr_win_q <= werr_win_d;
            wslverr_q  <= wslverr_d;
            wbeats_q   <= wbeats_d;
            awready_q  <= (wstate_d == W_ADDR);
            wready_q   <= (wstate_d == W_DATA);
            bvalid_q   <= (wstate_d == W_RESP);
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            en_q       <= en_d;
            en_dly_q   <= en_q;
            start_q    <= en_q & ~en_dly_q;
        end
    end

    assign axi.AWREADY_S = awready_q;
    assign axi.WREADY_S  = wready_q;
    assign axi.BVALID_S  = bvalid_q;
    assign axi.BID_S     = wid_q;
    assign axi.BRESP_S   = wslverr_q ? 2'b10 : 2'b00;

    assign dma_src   = src_q;
    assign dma_dst   = dst_q;
    assign dma_len   = len_q;
    assign dma_en    = en_q;
    assign dma_start = start_q;

`ifdef DMA_CFG_READBACK_EN
    typedef enum logic {R_ADDR, R_DATA} rstate_e;

    rstate_e     rstate_q, rstate_d;
    logic [7:0]  rid_q, rid_d;
    logic [1:0]  ridx_q, ridx_d;
    logic        rerr_q, rerr_d;
    logic [4:0]  rbeats_q, rbeats_d;
    logic        arready_q, rvalid_q;
    logic        ar_fire, r_fire;
    logic [31:0] rdata;

    assign ar_fire = arready_q & axi.ARVALID_S;
    assign r_fire  = rvalid_q & axi.RREADY_S;

    // Reads see register state before any same-cycle write lands.
    always_comb begin
        case (ridx_q)
            2'd0:    rdata = {31'd0, en_q};
            2'd1:    rdata = src_q;
            2'd2:    rdata = dst_q;
            default: rdata = 32'(len_q);
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        ridx_d   = ridx_q;
        rerr_d   = rerr_q;
        rbeats_d = rbeats_q;
        case (rstate_q)
            R_ADDR: begin
                if (ar_fire) begin
                    rid_d    = axi.ARID_S;
                    ridx_d   = axi.ARADDR_S[ADDR_LSB+1:ADDR_LSB];
                    rerr_d   = |axi.ARADDR_S[15:ADDR_LSB+2];
                    rbeats_d = {1'b0, axi.ARLEN_S} + 5'd1;
                    rstate_d = R_DATA;
                end
            end
            default: begin
                if (r_fire) begin
                    ridx_d   = ridx_q + 2'd1;
                    rbeats_d = rbeats_q - 5'd1;
                    if (rbeats_q == 5'd1) rstate_d = R_ADDR;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q  <= R_ADDR;
            rid_q     <= '0;
            ridx_q    <= '0;
            rerr_q    <= 1'b0;
            rbeats_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rerr_q    <= rerr_d;
            rbeats_q  <= rbeats_d;
            arready_q <= (rstate_d == R_ADDR);
            rvalid_q  <= (rstate_d == R_DATA);
        end
    end

    assign axi.ARREADY_S = arready_q;
    assign axi.RVALID_S  = rvalid_q;
    assign axi.RID_S     = rid_q;
    assign axi.RDATA_S   = rerr_q ? 32'd0 : rdata;
    assign axi.RRESP_S   = rerr_q ? 2'b10 : 2'b00;
    assign axi.RLAST_S   = rvalid_q & (rbeats_q == 5'd1);

    logic unused_rd;
    assign unused_rd = ^{axi.ARSIZE_S, axi.ARBURST_S, axi.ARADDR_S[31:16], axi.ARADDR_S[ADDR_LSB-1:0]};
`endif

    logic unused_wr;
    assign unused_wr = ^{axi.AWSIZE_S, axi.AWBURST_S, axi.AWADDR_S[31:16],
                         axi.AWADDR_S[ADDR_LSB-1:0], len_merged};
endmodule

// File: tb/tb_dma_cfg_slave.sv
// Self-checking bench for dma_cfg_slave: expected B responses are queued when a write is
// issued and compared when the B handshake happens; register values are checked per scenario.
module tb_dma_cfg_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] dma_src, dma_dst, dma_len;
    logic        dma_en, dma_start;
    logic        dma_done = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    int   cyc = 0;
    int   wlast_edge = -1;
    int   en_rise_at = -1;
    int   start_at = -1;
    int   start_cnt = 0;
    logic en_prev = 1'b0;

    logic [31:0] wbuf [4];
    logic        done_on_last = 1'b0;
    logic [9:0]  exp_q [$];

    dma_cfg_slave_if bus ();

    dma_cfg_slave #(.ADDR_LSB(2), .LEN_BITS(32)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .axi       (bus),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst),
        .dma_len   (dma_len),
        .dma_en    (dma_en),
        .dma_start (dma_start),
        .dma_done  (dma_done)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc++;

    // cyc at a negedge = number of rising edges so far; a handshake seen now lands on edge cyc+1.
    always @(negedge ACLK) begin
        if (bus.WVALID_S && bus.WREADY_S && bus.WLAST_S) wlast_edge = cyc + 1;
        if (dma_en && !en_prev) en_rise_at = cyc;
        if (dma_start) begin
            start_cnt++;
            start_at = cyc;
        end
        en_prev = dma_en;
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input int awlen,
                            input int nbeats, input logic [3:0] strb, input int bp_cycles,
                            input logic [1:0] exp_resp);
        int n;
        logic [9:0] exp;
        exp_q.push_back({id, exp_resp});
        bus.AWID_S    = id;
        bus.AWADDR_S  = addr;
        bus.AWLEN_S   = 4'(awlen);
        bus.AWVALID_S = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!bus.AWREADY_S && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!bus.AWREADY_S) begin
            tests_run++;
            tests_failed++;
            $display("FAIL aw_timeout id=%h: AWREADY_S=%b required 1", id, bus.AWREADY_S);
        end
        @(posedge ACLK);
        #1;
        bus.AWVALID_S = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.WDATA_S  = wbuf[b];
            bus.WSTRB_S  = strb;
            bus.WLAST_S  = (b == nbeats - 1);
            bus.WVALID_S = 1'b1;
            if (b == nbeats - 1 && done_on_last) dma_done = 1'b1;
            n = 0;
            @(negedge ACLK);
            while (!bus.WREADY_S && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            if (!bus.WREADY_S) begin
                tests_run++;
                tests_failed++;
                $display("FAIL w_timeout id=%h beat=%0d: WREADY_S=%b required 1", id, b, bus.WREADY_S);
            end
            @(posedge ACLK);
            #1;
            dma_done = 1'b0;
        end
        bus.WVALID_S = 1'b0;
        bus.WLAST_S  = 1'b0;
        @(negedge ACLK);
        tests_run++;
        if (bus.BVALID_S !== 1'b1) begin
            tests_failed++;
            $display("FAIL b_latency id=%h: BVALID_S=%b required 1 one cycle after last beat", id, bus.BVALID_S);
        end
        n = 0;
        while (!bus.BVALID_S && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        for (int k = 0; k < bp_cycles; k++) begin
            tests_run++;
            if (bus.BVALID_S !== 1'b1 || bus.AWREADY_S !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure cycle=%0d: BVALID_S=%b AWREADY_S=%b required 1/0",
                         k, bus.BVALID_S, bus.AWREADY_S);
            end
            @(negedge ACLK);
        end
        bus.BREADY_S = 1'b1;
        exp = exp_q.pop_front();
        tests_run++;
        if (bus.BID_S !== exp[9:2] || bus.BRESP_S !== exp[1:0]) begin
            tests_failed++;
            $display("FAIL bresp: BID_S=%h BRESP_S=%b required %h/%b", bus.BID_S, bus.BRESP_S, exp[9:2], exp[1:0]);
        end
        @(posedge ACLK);
        #1;
        bus.BREADY_S = 1'b0;
    endtask

    task automatic pulse_done();
        dma_done = 1'b1;
        @(posedge ACLK);
        #1;
        dma_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        tests_run++;
        if ({dma_src, dma_dst, dma_len, dma_en, dma_start} !== '0 ||
            {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.BID_S, bus.BRESP_S} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: src=%h dst=%h len=%h en=%b start=%b awr=%b wr=%b bv=%b bid=%h bresp=%b required all 0",
                     dma_src, dma_dst, dma_len, dma_en, dma_start, bus.AWREADY_S, bus.WREADY_S,
                     bus.BVALID_S, bus.BID_S, bus.BRESP_S);
        end
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_single_writes();
        wbuf[0] = 32'h0001_0000;
        do_write(32'h4, 8'h11, 0, 1, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h0002_0000;
        do_write(32'h8, 8'h22, 0, 1, 4'hF, 0, 2'b00);
        wbuf[0] = 32'd16;
        do_write(32'hC, 8'h33, 0, 1, 4'hF, 0, 2'b00);
        tests_run++;
        if (dma_src !== 32'h0001_0000 || dma_dst !== 32'h0002_0000 || dma_len !== 32'd16) begin
            tests_failed++;
            $display("FAIL single_writes: src=%h dst=%h len=%h required 00010000/00020000/00000010",
                     dma_src, dma_dst, dma_len);
        end
    endtask

    task automatic test_enable();
        start_cnt  = 0;
        en_rise_at = -1;
        start_at   = -1;
        wbuf[0] = 32'h0000_0001;
        do_write(32'h0, 8'h21, 0, 1, 4'hF, 0, 2'b00);
        repeat (3) @(negedge ACLK);
        tests_run++;
        if (en_rise_at !== wlast_edge) begin
            tests_failed++;
            $display("FAIL en_latency: dma_en rose at edge %0d required %0d", en_rise_at, wlast_edge);
        end
        tests_run++;
        if (start_cnt !== 1 || start_at !== wlast_edge + 1) begin
            tests_failed++;
            $display("FAIL start_pulse: %0d cycles high, at edge %0d required 1 at %0d",
                     start_cnt, start_at, wlast_edge + 1);
        end
        @(posedge ACLK);
        #1;
        pulse_done();
        tests_run++;
        if (dma_en !== 1'b0 || start_cnt !== 1) begin
            tests_failed++;
            $display("FAIL done_clears: dma_en=%b start_cnt=%0d required 0/1", dma_en, start_cnt);
        end
    endtask

    task automatic test_burst();
        wbuf[0] = 32'hA000_000A;
        wbuf[1] = 32'hB000_000B;
        wbuf[2] = 32'h0000_0C0C;
        wbuf[3] = 32'h0000_000D;
        do_write(32'h4, 8'h31, 3, 4, 4'hF, 0, 2'b00);
        tests_run++;
        if (dma_src !== 32'hA000_000A || dma_dst !== 32'hB000_000B || dma_len !== 32'h0000_0C0C || dma_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_wrap: src=%h dst=%h len=%h en=%b required A000000A/B000000B/00000C0C/1",
                     dma_src, dma_dst, dma_len, dma_en);
        end
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL burst_one_b: %0d responses outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_lock_and_strobes();
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h4, 8'h41, 0, 1, 4'hF, 0, 2'b00);
        tests_run++;
        if (dma_src !== 32'hA000_000A) begin
            tests_failed++;
            $display("FAIL lock_src: dma_src=%h required A000000A", dma_src);
        end
        pulse_done();
        wbuf[0] = 32'h0000_0000;
        do_write(32'h8, 8'h42, 0, 1, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h0000_AB00;
        do_write(32'h8, 8'h43, 0, 1, 4'b0010, 0, 2'b00);
        tests_run++;
        if (dma_dst !== 32'h0000_AB00) begin
            tests_failed++;
            $display("FAIL strobe_lane1: dma_dst=%h required 0000AB00", dma_dst);
        end
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h8, 8'h44, 0, 1, 4'b0001, 0, 2'b00);
        tests_run++;
        if (dma_dst !== 32'h0000_ABFF) begin
            tests_failed++;
            $display("FAIL strobe_lane0: dma_dst=%h required 0000ABFF", dma_dst);
        end
    endtask

    task automatic test_error();
        wbuf[0] = 32'h0000_0001;
        do_write(32'h0001_0010, 8'h51, 0, 1, 4'hF, 0, 2'b10);
        wbuf[0] = 32'h1234_5678;
        do_write(32'h0000_8014, 8'h52, 0, 1, 4'hF, 0, 2'b10);
        tests_run++;
        if (dma_en !== 1'b0 || dma_src !== 32'hA000_000A || dma_dst !== 32'h0000_ABFF || dma_len !== 32'h0000_0C0C) begin
            tests_failed++;
            $display("FAIL out_of_window: en=%b src=%h dst=%h len=%h required 0/A000000A/0000ABFF/00000C0C",
                     dma_en, dma_src, dma_dst, dma_len);
        end
        // AWLEN says two beats but WLAST arrives on the first.
        wbuf[0] = 32'h0000_0040;
        do_write(32'hC, 8'h53, 1, 1, 4'hF, 0, 2'b10);
        // Backpressured single write; BVALID must hold and AW must stay blocked.
        wbuf[0] = 32'd32;
        do_write(32'hC, 8'h54, 0, 1, 4'hF, 5, 2'b00);
        tests_run++;
        if (dma_len !== 32'd32) begin
            tests_failed++;
            $display("FAIL backpressure_len: dma_len=%h required 00000020", dma_len);
        end
    endtask

    task automatic test_collision();
        wbuf[0] = 32'h0000_0001;
        do_write(32'h0, 8'h61, 0, 1, 4'hF, 0, 2'b00);
        repeat (3) @(negedge ACLK);
        start_cnt = 0;
        @(posedge ACLK);
        #1;
        done_on_last = 1'b1;
        do_write(32'h0, 8'h62, 0, 1, 4'hF, 0, 2'b00);
        done_on_last = 1'b0;
        repeat (3) @(negedge ACLK);
        tests_run++;
        if (dma_en !== 1'b1 || start_cnt !== 0) begin
            tests_failed++;
            $display("FAIL done_vs_write: dma_en=%b start pulses=%0d required 1/0", dma_en, start_cnt);
        end
        @(posedge ACLK);
        #1;
        pulse_done();
    endtask

    task automatic test_reset_mid_burst();
        int   n;
        logic saw_b;
        bus.AWID_S    = 8'h71;
        bus.AWADDR_S  = 32'h4;
        bus.AWLEN_S   = 4'd3;
        bus.AWVALID_S = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!bus.AWREADY_S && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1;
        bus.AWVALID_S = 1'b0;
        bus.WDATA_S   = 32'h1111_1111;
        bus.WSTRB_S   = 4'hF;
        bus.WLAST_S   = 1'b0;
        bus.WVALID_S  = 1'b1;
        @(posedge ACLK);
        #1;
        tests_run++;
        if (dma_src !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL mid_burst_beat1: dma_src=%h required 11111111", dma_src);
        end
        bus.WDATA_S = 32'h2222_2222;
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        tests_run++;
        if ({dma_src, dma_dst, dma_len, dma_en, dma_start} !== '0 ||
            {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.BID_S, bus.BRESP_S} !== '0) begin
            tests_failed++;
            $display("FAIL mid_burst_reset: src=%h dst=%h len=%h en=%b start=%b awr=%b wr=%b bv=%b bid=%h required all 0",
                     dma_src, dma_dst, dma_len, dma_en, dma_start, bus.AWREADY_S, bus.WREADY_S,
                     bus.BVALID_S, bus.BID_S);
        end
        @(negedge ACLK);
        ARESETn      = 1'b1;
        bus.WVALID_S = 1'b0;
        bus.BREADY_S = 1'b1;
        saw_b = 1'b0;
        repeat (6) begin
            @(negedge ACLK);
            if (bus.BVALID_S) saw_b = 1'b1;
        end
        bus.BREADY_S = 1'b0;
        tests_run++;
        if (saw_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_burst_no_b: BVALID_S seen=%b required 0", saw_b);
        end
        @(posedge ACLK);
        #1;
        wbuf[0] = 32'h0000_5555;
        do_write(32'h8, 8'h72, 0, 1, 4'hF, 0, 2'b00);
        tests_run++;
        if (dma_dst !== 32'h0000_5555 || dma_src !== 32'h0) begin
            tests_failed++;
            $display("FAIL after_reset_write: dst=%h src=%h required 00005555/00000000", dma_dst, dma_src);
        end
    endtask

    initial begin
        bus.AWID_S    = '0;
        bus.AWADDR_S  = '0;
        bus.AWLEN_S   = '0;
        bus.AWSIZE_S  = 3'd2;
        bus.AWBURST_S = 2'b01;
        bus.AWVALID_S = 1'b0;
        bus.WDATA_S   = '0;
        bus.WSTRB_S   = '0;
        bus.WLAST_S   = 1'b0;
        bus.WVALID_S  = 1'b0;
        bus.BREADY_S  = 1'b0;
`ifdef DMA_CFG_READBACK_EN
        bus.ARID_S    = '0;
        bus.ARADDR_S  = '0;
        bus.ARLEN_S   = '0;
        bus.ARSIZE_S  = 3'd2;
        bus.ARBURST_S = 2'b01;
        bus.ARVALID_S = 1'b0;
        bus.RREADY_S  = 1'b0;
`endif
        test_reset();
        test_single_writes();
        test_enable();
        test_burst();
        test_lock_and_strobes();
        test_error();
        test_collision();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
